registro_solicitudes: RTL and testbench
=======================================

REGISTRO_SOLICITUDES -- requirements
Module: registro_solicitudes

Interface
REQ-001 Parameter N_PISOS, default 4, number of floors (request bits), legal range 2..32.
REQ-002 Parameter CW, default $clog2(N_PISOS+1), width of the count output.
REQ-003 Parameter IW, default $clog2(N_PISOS), width of the index outputs.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 D  input  N_PISOS  request inputs, bit i = call for floor i.
REQ-007 clr  input  N_PISOS  service-done inputs, bit i = floor i attended.
REQ-008 Q  output  N_PISOS  registered pending-request vector.
REQ-009 any  output  1  high when any bit of Q is set.
REQ-010 count  output  CW  number of set bits in Q.
REQ-011 lowest  output  IW  index of lowest set bit of Q.
REQ-012 highest  output  IW  index of highest set bit of Q.

Function
REQ-013 Per bit, on each rising clk: Q[i] <= (Q[i] & ~clr[i]) | set[i]; set[] is defined in REQ-023/024.
REQ-014 Latency: a request sampled at edge k shall appear on Q immediately after edge k, one cycle after D is driven.
REQ-015 A pending bit shall hold indefinitely with D low and clr low.
REQ-016 Simultaneous set[i]=1 and clr[i]=1 on the same edge: set wins, Q[i]=1 (no request lost).
REQ-017 clr on a bit already 0 with no set: no effect, Q[i] stays 0.
REQ-018 Bits are independent; set/clear of bit i never affects bit j.
REQ-019 any, count, lowest, highest shall be purely combinational from Q (no extra latency).
REQ-020 When Q=0: any=0, count=0, lowest=0, highest=0.
REQ-021 With a single set bit i: lowest=highest=i; with all bits set: count=N_PISOS.

Reset
REQ-022 rst_n low shall immediately, without waiting for clk, force Q=0 and any internal D history register to 0; the derived outputs follow REQ-020; D and clr are ignored while rst_n is low; the first update after release occurs at the first rising clk with rst_n high.

Configuration
REQ-023 Macro REGISTRO_SOLICITUDES_EDGE_EN defined: set[i] = D[i] & ~Dq[i], where Dq is D registered each clk (reset 0); only a 0->1 transition of D registers a request, so a held D does not re-arm a bit after clr.
REQ-024 Macro undefined: set[i] = D[i] (level-sensitive); a D held high keeps Q[i] set regardless of clr (REQ-016); no Dq register exists.

Verification (N_PISOS=4)
REQ-025 rst_n=0 with D=1111 -> Q=0000, any=0, count=0, lowest=0, highest=0; after release, D=1111 for one cycle -> Q=1111, count=4.
REQ-026 D=0101 for one cycle, then D=0000 -> Q=0101 after that edge and held; count=2, lowest=0, highest=2, any=1.
REQ-027 From Q=0101, clr=0001 for one cycle -> Q=0100, count=1, lowest=highest=2.
REQ-028 From Q=0100, D=0100 and clr=0100 on same edge -> Q=0100 (set wins).
REQ-029 D=1000 held high for 3 cycles, clr=1000 on cycle 2 -> with EDGE_EN Q[3]=0 after cycle 2; without it Q[3]=1 throughout.
REQ-030 Q=1111, rst_n pulsed low between clock edges -> Q=0000 before next rising edge, any=0.

Source files
------------

// File: rtl/registro_solicitudes.sv
// Purpose : pending floor-call register with occupancy count and lowest/highest pending index.
// Latency : a request sampled at a rising edge shows on Q right after that edge; summary outputs are combinational from Q.
// Backpress: none; D and clr are sampled every cycle, and a set on the same edge as a clear takes priority.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset, clears Q (and the D history when present)
//   D        request inputs, bit i = call for floor i
//   clr      service-done inputs, bit i = floor i attended
//   Q        registered pending-request vector
//   any      high when any bit of Q is set
//   count    number of set bits in Q
//   lowest   index of lowest set bit of Q (0 when Q is empty)
//   highest  index of highest set bit of Q (0 when Q is empty)
//
// Configuration macro: REGISTRO_SOLICITUDES_EDGE_EN
//   defined   -> a request is registered only on a 0->1 transition of D
//   undefined -> level-sensitive; a held D keeps its bit set
module registro_solicitudes #(
  parameter int N_PISOS = 4,
  parameter int CW      = $clog2(N_PISOS + 1),
  parameter int IW      = $clog2(N_PISOS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] D,
  input  logic [N_PISOS-1:0] clr,
  output logic [N_PISOS-1:0] Q,
  output logic               any,
  output logic [CW-1:0]      count,
  output logic [IW-1:0]      lowest,
  output logic [IW-1:0]      highest
);

  logic [N_PISOS-1:0] pend_q;
  logic [N_PISOS-1:0] pend_d;
  logic [N_PISOS-1:0] set_c;

`ifdef REGISTRO_SOLICITUDES_EDGE_EN
  // D history, used to detect rising edges so a held call cannot re-arm after service.
  logic [N_PISOS-1:0] d_hist_q;
  logic [N_PISOS-1:0] d_hist_d;

  always_comb begin
    set_c    = D & ~d_hist_q;
    d_hist_d = D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_hist_q <= '0;
    end else begin
      d_hist_q <= d_hist_d;
    end
  end
`else
  always_comb begin
    set_c = D;
  end
`endif

  // Set is OR-ed after the clear so a simultaneous set/clear leaves the bit pending.
  always_comb begin
    pend_d = (pend_q & ~clr) | set_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign Q = pend_q;

  // Summary outputs. The index scans rely on "last assignment wins":
  // the downward scan leaves the lowest set index, the upward scan the highest.
  always_comb begin
    any     = |pend_q;
    count   = '0;
    lowest  = '0;
    highest = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      count = count + CW'(pend_q[i]);
    end
    for (int i = N_PISOS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lowest = IW'(i);
      end
    end
    for (int i = 0; i < N_PISOS; i++) begin
      if (pend_q[i]) begin
        highest = IW'(i);
      end
    end
  end

endmodule

// File: tb/tb_registro_solicitudes.sv
module tb_registro_solicitudes;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic [3:0] clr;
  logic [3:0] Q;
  logic       any;
  logic [2:0] count;
  logic [1:0] lowest;
  logic [1:0] highest;

  int n_cmp;
  int n_bad;

  registro_solicitudes #(.N_PISOS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .clr     (clr),
    .Q       (Q),
    .any     (any),
    .count   (count),
    .lowest  (lowest),
    .highest (highest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] c;
    logic [3:0] q;
    logic [2:0] cnt;
    logic [1:0] lo;
    logic [1:0] hi;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       an;
    logic [2:0] cnt;
    logic [1:0] lo;
    logic [1:0] hi;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic check_all(input string nm, input exp_t e);
    cmp({nm, ".Q"}, 32'(Q), 32'(e.q));
    cmp({nm, ".any"}, 32'(any), 32'(e.an));
    cmp({nm, ".count"}, 32'(count), 32'(e.cnt));
    cmp({nm, ".lowest"}, 32'(lowest), 32'(e.lo));
    cmp({nm, ".highest"}, 32'(highest), 32'(e.hi));
  endtask

  // Called at a falling edge: drive inputs, queue the expectation, check after the next rising edge.
  task automatic step(input string nm, input logic [3:0] d, input logic [3:0] c,
                      input logic [3:0] q, input logic [2:0] cnt,
                      input logic [1:0] lo, input logic [1:0] hi);
    exp_t e;
    D   = d;
    clr = c;
    e.q = q; e.an = (q != 4'b0000); e.cnt = cnt; e.lo = lo; e.hi = hi;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check_all(nm, e);
    end
  endtask

  vec_t vt[15];
  exp_t zero_e;
  bit   edge_mode;

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef REGISTRO_SOLICITUDES_EDGE_EN
    edge_mode = 1'b1;
`else
    edge_mode = 1'b0;
`endif
    zero_e = '{q: 4'b0000, an: 1'b0, cnt: 3'd0, lo: 2'd0, hi: 2'd0};

    //           d        clr      q        cnt   lo    hi
    vt[0]  = '{4'b1111, 4'b0000, 4'b1111, 3'd4, 2'd0, 2'd3};
    vt[1]  = '{4'b0000, 4'b1111, 4'b0000, 3'd0, 2'd0, 2'd0};
    vt[2]  = '{4'b0101, 4'b0000, 4'b0101, 3'd2, 2'd0, 2'd2};
    vt[3]  = '{4'b0000, 4'b0000, 4'b0101, 3'd2, 2'd0, 2'd2};
    vt[4]  = '{4'b0000, 4'b0000, 4'b0101, 3'd2, 2'd0, 2'd2};
    vt[5]  = '{4'b0000, 4'b0001, 4'b0100, 3'd1, 2'd2, 2'd2};
    vt[6]  = '{4'b0100, 4'b0100, 4'b0100, 3'd1, 2'd2, 2'd2};
    vt[7]  = '{4'b0000, 4'b0100, 4'b0000, 3'd0, 2'd0, 2'd0};
    vt[8]  = '{4'b1000, 4'b0000, 4'b1000, 3'd1, 2'd3, 2'd3};
`ifdef REGISTRO_SOLICITUDES_EDGE_EN
    vt[9]  = '{4'b1000, 4'b1000, 4'b0000, 3'd0, 2'd0, 2'd0};
    vt[10] = '{4'b1000, 4'b0000, 4'b0000, 3'd0, 2'd0, 2'd0};
`else
    vt[9]  = '{4'b1000, 4'b1000, 4'b1000, 3'd1, 2'd3, 2'd3};
    vt[10] = '{4'b1000, 4'b0000, 4'b1000, 3'd1, 2'd3, 2'd3};
`endif
    vt[11] = '{4'b0000, 4'b1000, 4'b0000, 3'd0, 2'd0, 2'd0};
    vt[12] = '{4'b0010, 4'b0000, 4'b0010, 3'd1, 2'd1, 2'd1};
    vt[13] = '{4'b1001, 4'b0010, 4'b1001, 3'd2, 2'd0, 2'd3};
    vt[14] = '{4'b0000, 4'b1001, 4'b0000, 3'd0, 2'd0, 2'd0};

    // Reset with all requests asserted: they must be ignored.
    rst_n = 1'b0;
    D     = 4'b1111;
    clr   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check_all("reset", zero_e);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step($sformatf("vec%0d", i), vt[i].d, vt[i].c, vt[i].q, vt[i].cnt, vt[i].lo, vt[i].hi);
    end

    // Asynchronous reset mid-cycle from a full register.
    step("fill", 4'b1111, 4'b0000, 4'b1111, 3'd4, 2'd0, 2'd3);
    D = 4'b0000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", zero_e);
    D = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check_all("rst_ignores_d", zero_e);
    D = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_release", zero_e);

    // Random traffic against a reference of the update rule.
    begin
      logic [3:0] q_m;
      logic [3:0] dq_m;
      logic [3:0] rd;
      logic [3:0] rc;
      logic [3:0] s;
      logic [1:0] lo_m;
      logic [1:0] hi_m;
      q_m  = 4'b0000;
      dq_m = 4'b0000;
      for (int k = 0; k < 200; k++) begin
        rd = 4'($urandom_range(0, 15));
        rc = 4'($urandom_range(0, 15));
        s  = edge_mode ? (rd & ~dq_m) : rd;
        q_m  = (q_m & ~rc) | s;
        dq_m = rd;
        lo_m = 2'd0;
        hi_m = 2'd0;
        for (int b = 0; b < 4; b++) if (q_m[b]) hi_m = 2'(b);
        for (int b = 3; b >= 0; b--) if (q_m[b]) lo_m = 2'(b);
        step($sformatf("rnd%0d", k), rd, rc, q_m, 3'($countones(q_m)), lo_m, hi_m);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
